pack_s3: RTL and testbench

// - Packs a stream of S3 polynomial coefficients (trits 0/1/2) into bytes, five trits per byte, base 3.
// - Inverse of the unpack_s3 path: byte = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4, where t0 is the lowest-index coefficient.
// - Sits between the S3 arithmetic core and the key/ciphertext serialiser of the NTRU-HRSS KEM.

---
 rtl/ntru_s3_pkg.sv | 34 +++
 rtl/s3_mac8.sv | 52 +++++
 rtl/pack_s3.sv | 161 ++++++++++++++++
 tb/tb_pack_s3.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntru_s3_pkg.sv
// Shared definitions for the S3 (mod-3) coefficient packing path of NTRU-HRSS.
//   N_COEF_HRSS701 : coefficients packed per polynomial (n-1 for HRSS-701)
//   TPB            : trits per byte (3^5-1 = 242 fits in 8 bits)
//   N_BYTES_S3     : bytes per packed polynomial
//   s3_weight()    : 3^j weight table for slot j of a byte
//   s3_state_e     : packer FSM states
package ntru_s3_pkg;

  localparam int unsigned N_COEF_HRSS701 = 700;
  localparam int unsigned TPB            = 5;
  localparam int unsigned N_BYTES_S3     = (N_COEF_HRSS701 + TPB - 1) / TPB;

  // Weight of trit slot j within a byte; slots beyond TPB-1 never occur.
  function automatic logic [7:0] s3_weight(input logic [2:0] slot);
    logic [7:0] w;
    unique case (slot)
      3'd0:    w = 8'd1;
      3'd1:    w = 8'd3;
      3'd2:    w = 8'd9;
      3'd3:    w = 8'd27;
      3'd4:    w = 8'd81;
      default: w = 8'd0;
    endcase
    return w;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StEmit,
    StDone
  } s3_state_e;

endpackage

// File: rtl/s3_mac8.sv
// Combinational 8-bit multiply-accumulate for base-3 packing:
//   acc_o = acc_i + 3^w_sel_i * trit_i
// Ports:
//   acc_i   [7:0]  running byte accumulator
//   w_sel_i [2:0]  trit slot (0..4) selecting weight 3^slot
//   trit_i  [1:0]  trit value; 2'b11 contributes nothing
//   acc_o   [7:0]  updated accumulator (never exceeds 242, carry-out dropped)
// The weight product needs no multiplier: v is 0, 1 or 2, so w*v is 0, w or w<<1.
// The add is a Kogge-Stone prefix adder: half-adder row, then log2 levels of
// black (G,P) / grey (G only) combine cells.
module s3_mac8
  import ntru_s3_pkg::*;
(
  input  logic [7:0] acc_i,
  input  logic [2:0] w_sel_i,
  input  logic [1:0] trit_i,
  output logic [7:0] acc_o
);

  logic [7:0] w;
  logic [7:0] prod;
  logic [7:0] p;
  logic [6:0] g;
  logic [6:0] gg;
  logic [6:0] pp;

  always_comb begin
    w = s3_weight(w_sel_i);
    unique case (trit_i)
      2'd1:    prod = w;
      2'd2:    prod = {w[6:0], 1'b0};
      default: prod = 8'd0;
    endcase
  end

  always_comb begin
    // Half-adder row.
    p  = acc_i ^ prod;
    g  = acc_i[6:0] & prod[6:0];
    gg = g;
    pp = p[6:0];
    // Descending i so gg/pp[i-d] still hold the previous level's value.
    for (int d = 1; d < 7; d = d * 2) begin
      for (int i = 6; i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    acc_o = p ^ {gg, 1'b0};
  end

endmodule

// File: rtl/pack_s3.sv
// Packs a stream of S3 coefficients (trits 0..2) into bytes, five trits per byte:
//   byte = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4 (t0 = lowest-index coefficient).
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   start_i      begins a polynomial (only honoured when idle)
//   in_valid_i / in_ready_o / in_trit_i[1:0]    trit input handshake
//   out_valid_o / out_ready_i / out_byte_o[7:0]  byte output handshake
//   out_last_o   marks the final byte of the polynomial
//   busy_o       high in every state except idle
//   done_o       one-cycle pulse after the last byte is accepted
//   err_o        sticky: a trit of 2'b11 was accepted; cleared by start or reset
module pack_s3
  import ntru_s3_pkg::*;
#(
  parameter int unsigned NCoef = N_COEF_HRSS701
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [1:0] in_trit_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_byte_o,
  output logic       out_last_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int unsigned NBytes = (NCoef + TPB - 1) / TPB;
  localparam int unsigned CoefW  = $clog2(NCoef + 1);
  localparam int unsigned ByteW  = $clog2(NBytes + 1);
  localparam logic [CoefW-1:0] LastCoef = CoefW'(NCoef - 1);
  localparam logic [ByteW-1:0] LastByte = ByteW'(NBytes - 1);
  localparam logic [2:0]       LastSlot = 3'(TPB - 1);

  s3_state_e        state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [2:0]       slot_q, slot_d;
  logic [CoefW-1:0] coef_cnt_q, coef_cnt_d;
  logic [ByteW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       out_byte_q, out_byte_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             err_q, err_d;

  logic [1:0]       trit_v;
  logic [7:0]       mac_sum;
  logic             closing;

  // An illegal trit is folded to zero so it cannot corrupt the byte.
  assign trit_v  = (in_trit_i == 2'b11) ? 2'b00 : in_trit_i;
  // Final trit of a byte: full byte, or last coefficient of a short final byte.
  assign closing = (slot_q == LastSlot) || (coef_cnt_q == LastCoef);

  s3_mac8 u_mac (
    .acc_i   (acc_q),
    .w_sel_i (slot_q),
    .trit_i  (trit_v),
    .acc_o   (mac_sum)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    slot_d      = slot_q;
    coef_cnt_d  = coef_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StAccum;
          acc_d      = 8'd0;
          slot_d     = 3'd0;
          coef_cnt_d = '0;
          byte_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      StAccum: begin
        if (in_valid_i) begin
          if (in_trit_i == 2'b11) begin
            err_d = 1'b1;
          end
          if (closing) begin
            out_byte_d  = mac_sum;
            out_valid_d = 1'b1;
            out_last_d  = (byte_cnt_q == LastByte);
            state_d     = StEmit;
          end else begin
            acc_d      = mac_sum;
            slot_d     = slot_q + 3'd1;
            coef_cnt_d = coef_cnt_q + 1'b1;
          end
        end
      end
      StEmit: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          acc_d       = 8'd0;
          slot_d      = 3'd0;
          coef_cnt_d  = coef_cnt_q + 1'b1;
          if (out_last_q) begin
            out_last_d = 1'b0;
            state_d    = StDone;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = StAccum;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      acc_q       <= 8'd0;
      slot_q      <= 3'd0;
      coef_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      out_byte_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      slot_q      <= slot_d;
      coef_cnt_q  <= coef_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign in_ready_o  = (state_q == StAccum);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign out_valid_o = out_valid_q;
  assign out_byte_o  = out_byte_q;
  assign out_last_o  = out_last_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pack_s3.sv
// Bench for pack_s3: a 700-coefficient instance (index 0) for random full
// polynomials against a base-3 reference, and a 7-coefficient instance
// (index 1) for the table vectors and multi-cycle corner cases.
module tb_pack_s3;

  localparam int Budget = 50;
  localparam int NBig   = 700;
  localparam int NBigB  = 140;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2];
  logic       start[2];
  logic       in_valid[2];
  logic       in_ready[2];
  logic [1:0] in_trit[2];
  logic       out_valid[2];
  logic       out_ready[2];
  logic [7:0] out_byte[2];
  logic       out_last[2];
  logic       busy[2];
  logic       done[2];
  logic       err[2];

  pack_s3 #(.NCoef(700)) u_big (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_trit_i(in_trit[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_byte_o(out_byte[0]),
    .out_last_o(out_last[0]), .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0])
  );

  pack_s3 #(.NCoef(7)) u_small (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_trit_i(in_trit[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_byte_o(out_byte[1]),
    .out_last_o(out_last[1]), .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1])
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] t [5];
    logic [7:0] exp_b;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];
  int   trits[NBig];

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int e, input int xb, input int xe);
    vec_t v;
    v.t[0] = 2'(a); v.t[1] = 2'(b); v.t[2] = 2'(c); v.t[3] = 2'(d); v.t[4] = 2'(e);
    v.exp_b = 8'(xb);
    v.exp_err = 1'(xe);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no handshake within %0d cycles", name, Budget);
  endtask

  // All tasks start and finish on a falling edge.
  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    @(negedge clk);
    rst[k] = 1'b0;
  endtask

  task automatic do_start(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [1:0] t);
    int n = 0;
    in_valid[k] = 1'b1;
    in_trit[k]  = t;
    while (!in_ready[k] && n < Budget) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[k]) begin
      timed_out("send");
      in_valid[k] = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic recv(input int k, output logic [7:0] b, output logic l);
    int n = 0;
    out_ready[k] = 1'b1;
    while (!out_valid[k] && n < Budget) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid[k]) begin
      timed_out("recv");
      out_ready[k] = 1'b0;
      b = 8'h00;
      l = 1'b0;
      return;
    end
    b = out_byte[k];
    l = out_last[k];
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  task automatic check_idle(input int k, input string name);
    check({name, " in_ready"},  32'(in_ready[k]),  32'd0);
    check({name, " out_valid"}, 32'(out_valid[k]), 32'd0);
    check({name, " out_last"},  32'(out_last[k]),  32'd0);
    check({name, " busy"},      32'(busy[k]),      32'd0);
    check({name, " done"},      32'(done[k]),      32'd0);
    check({name, " err"},       32'(err[k]),       32'd0);
    check({name, " out_byte"},  32'(out_byte[k]),  32'd0);
  endtask

  // Reference: byte i is the base-3 number whose digits are coefficients 5i..5i+4.
  function automatic int ref_byte(input int idx);
    int acc = 0;
    int pw  = 1;
    for (int j = 0; j < 5; j++) begin
      if (5 * idx + j < NBig) acc += trits[5 * idx + j] * pw;
      pw *= 3;
    end
    return acc;
  endfunction

  initial begin
    logic [7:0] b;
    logic       l;
    int         done_cnt;

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; in_valid[k] = 1'b0;
      in_trit[k] = 2'd0; out_ready[k] = 1'b0;
    end
    vecs[0] = mk(1, 0, 0, 0, 0, 8'h01, 0);
    vecs[1] = mk(2, 2, 2, 2, 2, 8'hF2, 0);
    vecs[2] = mk(0, 1, 2, 0, 1, 8'h66, 0);
    vecs[3] = mk(0, 0, 0, 0, 1, 8'h51, 0);
    vecs[4] = mk(1, 2, 0, 1, 2, 8'hC4, 0);
    vecs[5] = mk(0, 0, 3, 0, 0, 8'h00, 1);

    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    check_idle(0, "reset big");
    check_idle(1, "reset small");

    // Table vectors: one full byte each.
    foreach (vecs[i]) begin
      do_reset(1);
      do_start(1);
      for (int j = 0; j < 5; j++) send(1, vecs[i].t[j]);
      recv(1, b, l);
      check($sformatf("vec%0d byte", i), 32'(b), 32'(vecs[i].exp_b));
      check($sformatf("vec%0d last", i), 32'(l), 32'd0);
      check($sformatf("vec%0d err", i),  32'(err[1]), 32'(vecs[i].exp_err));
    end

    // Seven-coefficient polynomial: full byte then a two-trit partial byte.
    do_reset(1);
    do_start(1);
    for (int j = 0; j < 5; j++) send(1, 2'd1);
    recv(1, b, l);
    check("n7 byte0", 32'(b), 32'h79);
    check("n7 last0", 32'(l), 32'd0);
    send(1, 2'd2);
    send(1, 2'd1);
    recv(1, b, l);
    check("n7 byte1", 32'(b), 32'h05);
    check("n7 last1", 32'(l), 32'd1);
    check("n7 done pulse", 32'(done[1]), 32'd1);
    check("n7 busy in done", 32'(busy[1]), 32'd1);
    check("n7 last cleared", 32'(out_last[1]), 32'd0);
    @(negedge clk);
    check("n7 done falls", 32'(done[1]), 32'd0);
    check("n7 busy falls", 32'(busy[1]), 32'd0);

    // Backpressure: hold the byte for 7 cycles while offering a trit.
    do_start(1);
    send(1, 2'd2); send(1, 2'd0); send(1, 2'd1); send(1, 2'd0); send(1, 2'd0);
    in_valid[1] = 1'b1;
    in_trit[1]  = 2'd2;
    for (int c = 0; c < 7; c++) begin
      check("bp out_valid", 32'(out_valid[1]), 32'd1);
      check("bp out_byte",  32'(out_byte[1]),  32'h0B);
      check("bp in_ready",  32'(in_ready[1]),  32'd0);
      @(negedge clk);
    end
    in_valid[1] = 1'b0;
    recv(1, b, l);
    check("bp byte0", 32'(b), 32'h0B);
    send(1, 2'd1);
    send(1, 2'd1);
    recv(1, b, l);
    check("bp byte1", 32'(b), 32'h04);
    check("bp last1", 32'(l), 32'd1);
    repeat (2) @(negedge clk);

    // Reset mid-polynomial aborts; out_byte (0x04 here) must clear.
    do_start(1);
    send(1, 2'd1); send(1, 2'd2); send(1, 2'd1);
    do_reset(1);
    check_idle(1, "midrst");
    do_start(1);
    send(1, 2'd1);
    for (int j = 0; j < 4; j++) send(1, 2'd0);
    recv(1, b, l);
    check("midrst fresh byte", 32'(b), 32'h01);

    // Illegal trit, sticky err, start ignored while busy.
    do_reset(1);
    do_start(1);
    send(1, 2'd0); send(1, 2'd0); send(1, 2'b11); send(1, 2'd0); send(1, 2'd0);
    recv(1, b, l);
    check("err byte", 32'(b), 32'h00);
    check("err set", 32'(err[1]), 32'd1);
    do_start(1);
    check("busy start busy", 32'(busy[1]), 32'd1);
    check("busy start err kept", 32'(err[1]), 32'd1);
    send(1, 2'd1);
    send(1, 2'd1);
    recv(1, b, l);
    check("busy start byte1", 32'(b), 32'h04);
    check("busy start last1", 32'(l), 32'd1);
    check("err sticky done", 32'(err[1]), 32'd1);
    @(negedge clk);
    check("err sticky idle", 32'(err[1]), 32'd1);
    do_start(1);
    check("err cleared by start", 32'(err[1]), 32'd0);
    do_reset(1);

    // Full random polynomials with random input gaps and output stalls.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NBig; i++) trits[i] = int'($urandom_range(0, 2));
      do_start(0);
      for (int bi = 0; bi < NBigB; bi++) begin
        for (int j = 0; j < 5; j++) begin
          if (5 * bi + j < NBig) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send(0, 2'(trits[5 * bi + j]));
          end
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        recv(0, b, l);
        check($sformatf("poly%0d byte%0d", r, bi), 32'(b), 32'(ref_byte(bi)));
        check($sformatf("poly%0d last%0d", r, bi), 32'(l), 32'(bi == NBigB - 1));
      end
      check("poly busy with done", 32'(busy[0]), 32'd1);
      done_cnt = 0;
      for (int c = 0; c < 5; c++) begin
        if (done[0]) done_cnt++;
        @(negedge clk);
      end
      check("poly done count", 32'(done_cnt), 32'd1);
      check("poly busy after", 32'(busy[0]), 32'd0);
      check("poly no extra byte", 32'(out_valid[0]), 32'd0);
      check("poly in_ready idle", 32'(in_ready[0]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
